mips_run_dump_ctrl: RTL
=======================

// Module: mips_run_dump_ctrl
// PURPOSE
//   Synthesizable run/dump controller for the single-cycle MIPS core. Gates the core via
//   run_en for a programmable cycle budget or until a halt instruction, then streams the
//   register file and/or data memory out over a valid/ready port, word by word.
//   Sits beside the core and turns the fixed "run N ns, then dump" flow into a counted,
//   selectable, back-pressured sequence usable on hardware and in benches.
// PARAMETERS
//   DATA_W      32   width of register and memory words
//   REG_COUNT   32   register-file entries dumped; REG_AW = $clog2(REG_COUNT)
//   DMEM_DEPTH  256  data-memory words dumped; MEM_AW = $clog2(DMEM_DEPTH)
//   CNT_W       16   cycle-counter width
// PORTS
//   clock        in   1          system clock, rising edge
//   reset_n      in   1          synchronous, active-low reset
//   start        in   1          pulse: begin run (accepted in IDLE/DONE only)
//   cycle_limit  in   CNT_W      max run cycles; 0 = unlimited (sample at start)
//   dump_sel     in   2          [0] dump regs, [1] dump dmem (sample at start)
//   halt_req     in   1          core decodes halt instruction this cycle
//   run_en       out  1          core state-update enable
//   reg_rd_addr  out  REG_AW     register-file debug read address (comb. read)
//   reg_rd_data  in   DATA_W     register-file debug read data
//   mem_rd_addr  out  MEM_AW     data-memory debug read address (comb. read)
//   mem_rd_data  in   DATA_W     data-memory debug read data
//   dump_valid   out  1          dump word available
//   dump_ready   in   1          sink accepts word
//   dump_data    out  DATA_W     dump word
//   dump_src     out  1          0 = register file, 1 = data memory
//   dump_index   out  MEM_AW     word index within source
//   dump_last    out  1          final word of whole dump
//   busy / done  out  1 / 1      in RUN or DUMP_* / in DONE
//   cycles_run   out  CNT_W      committed run cycles
//   halt_cause   out  2          [0] limit reached, [1] halt_req
// BEHAVIOUR
//   Reset (reset_n=0 at edge): state IDLE; every output 0; index, cycles_run, halt_cause,
//     latched limit/sel cleared. Overrides any state, incl. mid-RUN/mid-dump.
//   FSM: IDLE, RUN, DUMP_REG, DUMP_MEM, DONE.
//   IDLE/DONE + start: latch cycle_limit, dump_sel; clear cycles_run, halt_cause, index; -> RUN.
//   start ignored in RUN/DUMP_*.
//   RUN, run_en combinational = (state==RUN) & ~halt_req & ~limit_hit, where
//     limit_hit = (lim!=0 & cycles_run==lim) | (cycles_run==all-ones).
//     run_en=1: cycles_run++. Else leave RUN; halt_cause = {halt_req, limit_hit} (both may set);
//     the halting instruction is never committed.
//     Exit target: sel[0] -> DUMP_REG; else sel[1] -> DUMP_MEM; else DONE.
//   DUMP_*: dump_valid=1; address = index; dump_data = selected rd_data (combinational);
//     data/index/src stable while valid & ~ready. On valid & ready: index++; at REG_COUNT-1
//     in DUMP_REG -> index=0, DUMP_MEM if sel[1] else DONE; at DMEM_DEPTH-1 -> DONE.
//     dump_last = valid on final word of the last selected region. No timeout on ready.
//   DONE: done=1, outputs hold cycles_run/halt_cause until next start or reset.
//   Outside DUMP_*: dump_valid=0, rd_addr=0.
// STRUCTURE
//   Package mips_dbg_pkg: state enum, HALT_CAUSE_* bit positions, DUMP_SRC_REG/MEM.
//   One sub-module: mips_dump_seq (index counter, valid/ready, last flag, region wrap);
//   top holds FSM, cycle counter, latches.
// TESTING
//   Reset 3 cycles with start=1, halt_req=1 -> run_en, busy, done, dump_valid all 0.
//   start, limit=60, sel=00, halt_req=0 -> run_en high exactly 60 cycles, cycles_run=60,
//     halt_cause=01, done=1 next cycle.
//   start, limit=60, halt_req in 10th RUN cycle -> 9 run_en cycles, cycles_run=9, cause=10;
//     halt coinciding with cycle 61 check -> cause=11.
//   sel=11, ready=1 always, preloaded regs/dmem -> 288 transfers: src0 idx 0..31, src1 idx
//     0..255, data matches preload, dump_last only on transfer 288.
//   sel=10, ready random 30% -> no skipped/duplicated index, fields stable while stalled.
//   reset_n low during DUMP_MEM idx 100 -> IDLE next edge, outputs 0; new start counts from 0.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_dbg_pkg
// Description : Shared types and constants for the MIPS run/dump controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DUMP_REG = 3'd2,
        ST_DUMP_MEM = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Bit positions inside halt_cause
    localparam int HALT_CAUSE_LIMIT = 0;
    localparam int HALT_CAUSE_HALT  = 1;

    // dump_src encoding
    localparam logic DUMP_SRC_REG = 1'b0;
    localparam logic DUMP_SRC_MEM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mips_dump_seq.sv
`default_nettype none
// ============================================================================
// Module      : mips_dump_seq
// Description : Dump word sequencer - index counter, valid/ready handshake,
//               region-end detection and final-word flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dump_seq
    import mips_dbg_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int DMEM_DEPTH = 256,
    parameter int MEM_AW     = $clog2(DMEM_DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_active,
    input  logic              i_region,
    input  logic              i_mem_sel,
    input  logic              i_ready,
    output logic [MEM_AW-1:0] o_index,
    output logic              o_valid,
    output logic              o_fire,
    output logic              o_region_end,
    output logic              o_last
);

    localparam logic [MEM_AW-1:0] c_REG_LAST = MEM_AW'(REG_COUNT - 1);
    localparam logic [MEM_AW-1:0] c_MEM_LAST = MEM_AW'(DMEM_DEPTH - 1);

    logic [MEM_AW-1:0] r_index;
    logic              w_at_end;

    // Region end depends on which source is currently being streamed
    always_comb begin
        w_at_end = (i_region == DUMP_SRC_MEM) ? (r_index == c_MEM_LAST)
                                              : (r_index == c_REG_LAST);
    end

    assign o_valid      = i_active;
    assign o_fire       = i_active & i_ready;
    assign o_region_end = w_at_end;
    // Register region is only the final one when memory is not selected
    assign o_last       = i_active & w_at_end & ((i_region == DUMP_SRC_MEM) | ~i_mem_sel);
    assign o_index      = i_active ? r_index : '0;

    // Index advances only on an accepted word; wraps to 0 at the region end
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_index <= '0;
        end else if (i_clear) begin
            r_index <= '0;
        end else if (o_fire) begin
            r_index <= w_at_end ? '0 : r_index + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_run_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_dump_ctrl
// Description : Run/dump controller for the single-cycle MIPS core. Gates the
//               core for a cycle budget or until halt, then streams register
//               file and/or data memory over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_run_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int REG_COUNT  = 32,
    parameter  int DMEM_DEPTH = 256,
    parameter  int CNT_W      = 16,
    localparam int REG_AW     = $clog2(REG_COUNT),
    localparam int MEM_AW     = $clog2(DMEM_DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_cycle_limit,
    input  logic [1:0]        i_dump_sel,
    input  logic              i_halt_req,
    output logic              o_run_en,
    output logic [REG_AW-1:0] o_reg_rd_addr,
    input  logic [DATA_W-1:0] i_reg_rd_data,
    output logic [MEM_AW-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_src,
    output logic [MEM_AW-1:0] o_dump_index,
    output logic              o_dump_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_cycles_run,
    output logic [1:0]        o_halt_cause
);

    state_t            r_state;
    state_t            w_next_state;
    state_t            w_run_exit;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  r_limit;
    logic [1:0]        r_sel;
    logic [1:0]        r_halt_cause;

    logic              w_start_accept;
    logic              w_limit_hit;
    logic              w_run_en;
    logic              w_dump_active;
    logic              w_dump_mem;
    logic              w_fire;
    logic              w_region_end;
    logic [MEM_AW-1:0] w_index;

    assign w_start_accept = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    // Saturation at all-ones also stops the run so the counter never wraps
    assign w_limit_hit    = ((r_limit != '0) & (r_cycles == r_limit)) | (r_cycles == {CNT_W{1'b1}});
    assign w_run_en       = (r_state == ST_RUN) & ~i_halt_req & ~w_limit_hit;
    assign w_dump_mem     = (r_state == ST_DUMP_MEM);
    assign w_dump_active  = (r_state == ST_DUMP_REG) | w_dump_mem;

    mips_dump_seq #(
        .REG_COUNT  (REG_COUNT),
        .DMEM_DEPTH (DMEM_DEPTH),
        .MEM_AW     (MEM_AW)
    ) u_seq (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_clear      (w_start_accept),
        .i_active     (w_dump_active),
        .i_region     (w_dump_mem),
        .i_mem_sel    (r_sel[1]),
        .i_ready      (i_dump_ready),
        .o_index      (w_index),
        .o_valid      (o_dump_valid),
        .o_fire       (w_fire),
        .o_region_end (w_region_end),
        .o_last       (o_dump_last)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; RUN exits to the first selected dump region
    always_comb begin
        w_run_exit   = r_sel[0] ? ST_DUMP_REG : (r_sel[1] ? ST_DUMP_MEM : ST_DONE);
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_accept) w_next_state = ST_RUN;
            ST_RUN:           if (!w_run_en) w_next_state = w_run_exit;
            ST_DUMP_REG:      if (w_fire && w_region_end)
                                  w_next_state = r_sel[1] ? ST_DUMP_MEM : ST_DONE;
            ST_DUMP_MEM:      if (w_fire && w_region_end) w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    // Run latches, cycle counter and halt cause; cause captured on RUN exit
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cycles     <= '0;
            r_limit      <= '0;
            r_sel        <= '0;
            r_halt_cause <= '0;
        end else if (w_start_accept) begin
            r_cycles     <= '0;
            r_limit      <= i_cycle_limit;
            r_sel        <= i_dump_sel;
            r_halt_cause <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_run_en) begin
                r_cycles <= r_cycles + 1'b1;
            end else begin
                r_halt_cause[HALT_CAUSE_HALT]  <= i_halt_req;
                r_halt_cause[HALT_CAUSE_LIMIT] <= w_limit_hit;
            end
        end
    end

    assign o_run_en      = w_run_en;
    assign o_reg_rd_addr = (r_state == ST_DUMP_REG) ? w_index[REG_AW-1:0] : '0;
    assign o_mem_rd_addr = w_dump_mem ? w_index : '0;
    assign o_dump_data   = w_dump_mem ? i_mem_rd_data
                         : ((r_state == ST_DUMP_REG) ? i_reg_rd_data : '0);
    assign o_dump_src    = w_dump_mem ? DUMP_SRC_MEM : DUMP_SRC_REG;
    assign o_dump_index  = w_index;
    assign o_busy        = (r_state == ST_RUN) | w_dump_active;
    assign o_done        = (r_state == ST_DONE);
    assign o_cycles_run  = r_cycles;
    assign o_halt_cause  = r_halt_cause;

endmodule
`default_nettype wire
